// File: rtl/process_scheduler_if.sv
// Signal bundle between the process scheduler and the core/OS side.
// The master drives the requests and the slave (the scheduler) drives the switch controls.
interface process_scheduler_if #(
    parameter int ID_W      = 2,
    parameter int QUANTUM_W = 16
);
    logic                 sched_en;
    logic                 instr_retire;
    logic [31:0]          current_pc;
    logic [QUANTUM_W-1:0] quantum;
    logic                 create_valid;
    logic [ID_W-1:0]      create_id;
    logic [31:0]          create_pc;
    logic                 kill_valid;
    logic [ID_W-1:0]      kill_id;
    logic                 yield_req;
    logic                 switch_ack;
    logic                 switch_req;
    logic                 load_pc;
    logic [31:0]          new_pc;
    logic [ID_W-1:0]      current_id;
    logic                 idle;

    modport master (
        output sched_en, instr_retire, current_pc, quantum,
        output create_valid, create_id, create_pc,
        output kill_valid, kill_id, yield_req, switch_ack,
        input  switch_req, load_pc, new_pc, current_id, idle
    );

    modport slave (
        input  sched_en, instr_retire, current_pc, quantum,
        input  create_valid, create_id, create_pc,
        input  kill_valid, kill_id, yield_req, switch_ack,
        output switch_req, load_pc, new_pc, current_id, idle
    );
endinterface

// File: rtl/process_scheduler.sv
// Round-robin, quantum-based preemptive process scheduler for the single-cycle core.
// Optional macro PROCESS_SCHEDULER_YIELD_EN: when defined, yield_req ends the running slice.
module process_scheduler #(
    parameter int NPROC     = 4,
    parameter int ID_W      = 2,
    parameter int QUANTUM_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    process_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        SAVE,
        SELECT,
        LOAD
    } state_t;

    state_t               state_reg, state_next;
    logic [NPROC-1:0]     valid_reg, valid_next;
    logic [ID_W-1:0]      current_id_reg, current_id_next;
    logic [31:0]          new_pc_reg, new_pc_next;
    logic [QUANTUM_W-1:0] cnt_reg, cnt_next;
    logic                 no_save_reg, no_save_next;
    logic                 from_idle_reg, from_idle_next;

    logic [31:0]          slot_pc [NPROC];
    logic                 halt_core;
    logic                 load_strobe;
    logic                 save_en;
    logic                 yield_hit;
    logic [QUANTUM_W-1:0] quantum_eff;
    logic [ID_W-1:0]      search_base;
    logic [ID_W-1:0]      cand;
    logic [ID_W-1:0]      pick_id;
    logic                 pick_found;

`ifdef PROCESS_SCHEDULER_YIELD_EN
    assign yield_hit = bus.yield_req;
`else
    logic unused_yield;
    assign unused_yield = bus.yield_req;
    assign yield_hit    = 1'b0;
`endif

    // A zero quantum would never expire, so it behaves as a one-instruction slice.
    assign quantum_eff = (bus.quantum == '0) ? QUANTUM_W'(1) : bus.quantum;

    // Per-slot table entry: valid flag update and saved PC register.
    genvar gi;
    generate
        for (gi = 0; gi < NPROC; gi++) begin : g_slot
            logic        kill_hit;
            logic        create_hit;
            logic        save_hit;
            logic [31:0] pc_reg;

            assign kill_hit   = bus.kill_valid && (bus.kill_id == ID_W'(gi));
            assign create_hit = bus.create_valid && (bus.create_id == ID_W'(gi))
                                && !valid_reg[gi] && !kill_hit;
            assign save_hit   = save_en && (current_id_reg == ID_W'(gi));

            assign valid_next[gi] = kill_hit ? 1'b0 : (create_hit ? 1'b1 : valid_reg[gi]);

            // A create only lands on an invalid slot, so it overrides a save that raced a kill.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pc_reg <= '0;
                end else if (create_hit) begin
                    pc_reg <= bus.create_pc;
                end else if (save_hit) begin
                    pc_reg <= bus.current_pc;
                end
            end

            assign slot_pc[gi] = pc_reg;
        end
    endgenerate

    // Round-robin pick: scan upward from the slot after the base, the base itself last.
    always_comb begin
        search_base = from_idle_reg ? ID_W'(NPROC - 1) : current_id_reg;
        cand        = '0;
        pick_id     = '0;
        pick_found  = 1'b0;
        for (int k = NPROC; k >= 1; k--) begin
            cand = search_base + ID_W'(k);
            if (valid_reg[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        current_id_next = current_id_reg;
        new_pc_next     = new_pc_reg;
        cnt_next        = cnt_reg;
        no_save_next    = no_save_reg;
        from_idle_next  = from_idle_reg;
        halt_core       = 1'b0;
        load_strobe     = 1'b0;
        save_en         = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (bus.sched_en && (|valid_reg)) begin
                    state_next     = DRAIN;
                    no_save_next   = 1'b1;
                    from_idle_next = 1'b1;
                end
            end
            RUN: begin
                if (!bus.sched_en) begin
                    state_next = IDLE;
                end else if (!valid_reg[current_id_reg]) begin
                    state_next   = DRAIN;
                    no_save_next = 1'b1;
                end else if ((bus.instr_retire && (cnt_reg == QUANTUM_W'(1))) || yield_hit) begin
                    state_next = DRAIN;
                end else if (bus.instr_retire && (cnt_reg != '0)) begin
                    cnt_next = cnt_reg - QUANTUM_W'(1);
                end
            end
            DRAIN: begin
                halt_core = 1'b1;
                if (bus.switch_ack) begin
                    state_next = (no_save_reg || !valid_reg[current_id_reg]) ? SELECT : SAVE;
                end
            end
            SAVE: begin
                halt_core  = 1'b1;
                save_en    = 1'b1;
                state_next = SELECT;
            end
            SELECT: begin
                halt_core      = 1'b1;
                no_save_next   = 1'b0;
                from_idle_next = 1'b0;
                if (pick_found) begin
                    current_id_next = pick_id;
                    new_pc_next     = slot_pc[pick_id];
                    state_next      = LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            LOAD: begin
                halt_core   = 1'b1;
                load_strobe = 1'b1;
                cnt_next    = quantum_eff;
                state_next  = RUN;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            valid_reg      <= '0;
            current_id_reg <= '0;
            new_pc_reg     <= '0;
            cnt_reg        <= '0;
            no_save_reg    <= 1'b0;
            from_idle_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            valid_reg      <= valid_next;
            current_id_reg <= current_id_next;
            new_pc_reg     <= new_pc_next;
            cnt_reg        <= cnt_next;
            no_save_reg    <= no_save_next;
            from_idle_reg  <= from_idle_next;
        end
    end

    // Halt and load strobes decode the state directly so a reset drops them at once.
    assign bus.switch_req = halt_core;
    assign bus.load_pc    = load_strobe;
    assign bus.new_pc     = new_pc_reg;
    assign bus.current_id = current_id_reg;
    assign bus.idle       = (state_reg == IDLE);

endmodule
